// File: rtl/per_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : per_meas_ctrl
// Description : Sequences an external 9-bit period counter to time the
//               interval between synchronized rising edges of sig_in.
// Revision    : 1.0 - initial release
// ============================================================================
module per_meas_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       sig_in,
    input  logic [8:0] period,
    input  logic       vld_ack,
    output logic       clr_period,
    output logic [8:0] meas_period,
    output logic       meas_vld,
    output logic       ovfl
);

    localparam logic [1:0] C_IDLE    = 2'd0;
    localparam logic [1:0] C_ARM     = 2'd1;
    localparam logic [1:0] C_MEAS    = 2'd2;
    localparam logic [8:0] C_PER_MAX = 9'h1FF;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic       w_rise;
    logic       w_at_max;
    logic       w_capture;
    logic       w_ovf_evt;

    // Two flops for metastability, third for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise   = r_s2 & ~r_s3;
    assign w_at_max = (period == C_PER_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!en) begin
            w_next_state = C_IDLE;
        end else begin
            case (r_state)
                C_IDLE:  w_next_state = C_ARM;
                C_ARM:   if (w_rise) w_next_state = C_MEAS;
                C_MEAS:  if (w_at_max) w_next_state = C_ARM;
                default: w_next_state = C_IDLE;
            endcase
        end
    end

    // A full-scale count is an overflow even when a rise lands on it.
    always_comb begin
        clr_period = 1'b1;
        w_capture  = 1'b0;
        w_ovf_evt  = 1'b0;
        if (r_state == C_MEAS) begin
            clr_period = w_rise;
            w_ovf_evt  = en & w_at_max;
            w_capture  = en & w_rise & ~w_at_max;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_period <= 9'h000;
            meas_vld    <= 1'b0;
            ovfl        <= 1'b0;
        end else begin
            if (w_capture) begin
                meas_period <= period + 9'd1;
            end
            if (w_capture) begin
                meas_vld <= 1'b1;
            end else if (vld_ack) begin
                meas_vld <= 1'b0;
            end
            if (w_ovf_evt) begin
                ovfl <= 1'b1;
            end else if (vld_ack) begin
                ovfl <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
